// File: rtl/axi4_lite_master_write_engine_pkg.sv
// ---------------------------------------------------------------------------
// Axi4LiteGlobalsPkg
// Shared definitions for the AXI4-Lite write initiator slice.
//   AXI_ADDRESS_WIDTH / AXI_DATA_WIDTH : default bus widths for the engine
//   axiResp_t                          : AXI response codes carried on B
//   writeState_t                       : write engine FSM states
// ---------------------------------------------------------------------------
package Axi4LiteGlobalsPkg;

    localparam int AXI_ADDRESS_WIDTH = 32;
    localparam int AXI_DATA_WIDTH    = 32;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'd0,
        RESP_EXOKAY = 2'd1,
        RESP_SLVERR = 2'd2,
        RESP_DECERR = 2'd3
    } axiResp_t;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ADDR_DATA = 2'd1,
        ST_WAIT_B    = 2'd2,
        ST_RESP      = 2'd3
    } writeState_t;

endpackage

// File: rtl/axi4_lite_master_write_engine_sat_counter.sv
// ---------------------------------------------------------------------------
// axi4_lite_sat_counter
// Up-counter that sticks at all-ones instead of wrapping, so a status
// register never appears to have gone backwards after a long run.
// Ports:
//   clk   : clock, rising edge
//   clr   : synchronous active-high clear (takes priority over inc)
//   inc   : add one this cycle unless already saturated
//   count : current value
// ---------------------------------------------------------------------------
module axi4_lite_sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] r_count;

    // Clear wins over increment; once every bit is set the value is frozen
    // until the next clear.
    always_ff @(posedge clk) begin
        if (clr) begin
            r_count <= '0;
        end else if (inc && (r_count != '1)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign count = r_count;

endmodule

// File: rtl/axi4_lite_master_write_engine.sv
// ---------------------------------------------------------------------------
// axi4_lite_master_write_engine
// Manager side of the AXI4-Lite write channels with a single outstanding
// transaction. A request taken on the req port is launched on AW and W
// independently, the B response is collected and handed back on the rsp
// port, and two saturating counters track completed and errored writes.
// DATA_WIDTH is expected to be 32 or 64.
// Ports:
//   aclk, areset                 : clock and synchronous active-high reset
//   req_valid/ready/addr/data/strb/prot : write request command port
//   rsp_valid/ready/resp         : write response port (captured bresp)
//   awaddr/awprot/awvalid/awready: AXI write address channel
//   wdata/wstrb/wvalid/wready    : AXI write data channel
//   bresp/bvalid/bready          : AXI write response channel
//   wr_count, err_count          : saturating status counters
// ---------------------------------------------------------------------------
module axi4_lite_master_write_engine
    import Axi4LiteGlobalsPkg::*;
#(
    parameter int ADDRESS_WIDTH = AXI_ADDRESS_WIDTH,
    parameter int DATA_WIDTH    = AXI_DATA_WIDTH,
    parameter int CNT_WIDTH     = 16
) (
    input  logic                      aclk,
    input  logic                      areset,

    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [ADDRESS_WIDTH-1:0]  req_addr,
    input  logic [DATA_WIDTH-1:0]     req_data,
    input  logic [DATA_WIDTH/8-1:0]   req_strb,
    input  logic [2:0]                req_prot,

    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [1:0]                rsp_resp,

    output logic [ADDRESS_WIDTH-1:0]  awaddr,
    output logic [2:0]                awprot,
    output logic                      awvalid,
    input  logic                      awready,

    output logic [DATA_WIDTH-1:0]     wdata,
    output logic [DATA_WIDTH/8-1:0]   wstrb,
    output logic                      wvalid,
    input  logic                      wready,

    input  logic [1:0]                bresp,
    input  logic                      bvalid,
    output logic                      bready,

    output logic [CNT_WIDTH-1:0]      wr_count,
    output logic [CNT_WIDTH-1:0]      err_count
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    writeState_t              r_state;
    logic                     r_awDone;
    logic                     r_wDone;
    logic                     r_awvalid;
    logic                     r_wvalid;
    logic                     r_bready;
    logic                     r_rspValid;
    logic [1:0]               r_rspResp;
    logic [ADDRESS_WIDTH-1:0] r_awaddr;
    logic [2:0]               r_awprot;
    logic [DATA_WIDTH-1:0]    r_wdata;
    logic [STRB_WIDTH-1:0]    r_wstrb;

    logic                     w_awFire;
    logic                     w_wFire;
    logic                     w_bFire;
    logic                     w_errInc;

    // Handshake strobes. B can only fire while bready is up, which keeps a
    // stray bvalid outside WAIT_B from being counted.
    assign w_awFire = r_awvalid && awready;
    assign w_wFire  = r_wvalid && wready;
    assign w_bFire  = r_bready && bvalid;
    assign w_errInc = w_bFire && (bresp != RESP_OKAY);

    // Accepting depends only on the state, so the requester never sees a
    // ready that reacts to its own valid.
    assign req_ready = (r_state == ST_IDLE);

    // Main write FSM. All channel outputs are registered here. The done
    // flags fold in the current-cycle handshakes so that AW and W finishing
    // together, or in either order, move to WAIT_B on the same edge as the
    // last handshake. Valids drop only on their own handshake edge, so the
    // payload registers stay untouched while a valid is pending.
    always_ff @(posedge aclk) begin
        if (areset) begin
            r_state    <= ST_IDLE;
            r_awDone   <= 1'b0;
            r_wDone    <= 1'b0;
            r_awvalid  <= 1'b0;
            r_wvalid   <= 1'b0;
            r_bready   <= 1'b0;
            r_rspValid <= 1'b0;
            r_rspResp  <= 2'b00;
            r_awaddr   <= '0;
            r_awprot   <= 3'b000;
            r_wdata    <= '0;
            r_wstrb    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (req_valid) begin
                        r_awaddr  <= req_addr;
                        r_awprot  <= req_prot;
                        r_wdata   <= req_data;
                        r_wstrb   <= req_strb;
                        r_awDone  <= 1'b0;
                        r_wDone   <= 1'b0;
                        r_awvalid <= 1'b1;
                        r_wvalid  <= 1'b1;
                        r_state   <= ST_ADDR_DATA;
                    end
                end

                ST_ADDR_DATA: begin
                    if (w_awFire) begin
                        r_awDone  <= 1'b1;
                        r_awvalid <= 1'b0;
                    end
                    if (w_wFire) begin
                        r_wDone  <= 1'b1;
                        r_wvalid <= 1'b0;
                    end
                    if ((r_awDone || w_awFire) && (r_wDone || w_wFire)) begin
                        r_bready <= 1'b1;
                        r_state  <= ST_WAIT_B;
                    end
                end

                ST_WAIT_B: begin
                    if (w_bFire) begin
                        r_rspResp  <= bresp;
                        r_bready   <= 1'b0;
                        r_rspValid <= 1'b1;
                        r_state    <= ST_RESP;
                    end
                end

                ST_RESP: begin
                    if (rsp_ready) begin
                        r_rspValid <= 1'b0;
                        r_state    <= ST_IDLE;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign awaddr    = r_awaddr;
    assign awprot    = r_awprot;
    assign awvalid   = r_awvalid;
    assign wdata     = r_wdata;
    assign wstrb     = r_wstrb;
    assign wvalid    = r_wvalid;
    assign bready    = r_bready;
    assign rsp_valid = r_rspValid;
    assign rsp_resp  = r_rspResp;

    // Status counters advance on the same edge that captures the response,
    // so they are already current when rsp_valid rises.
    axi4_lite_sat_counter #(
        .WIDTH (CNT_WIDTH)
    ) u_wrCounter (
        .clk   (aclk),
        .clr   (areset),
        .inc   (w_bFire),
        .count (wr_count)
    );

    axi4_lite_sat_counter #(
        .WIDTH (CNT_WIDTH)
    ) u_errCounter (
        .clk   (aclk),
        .clr   (areset),
        .inc   (w_errInc),
        .count (err_count)
    );

endmodule

// File: tb/tb_axi4_lite_master_write_engine.sv
// ---------------------------------------------------------------------------
// tb_axi4_lite_master_write_engine
// Directed and randomised write transactions against the write engine, with
// the bench acting as both requester and AXI slave. Expected channel
// contents, timing and counter values come from a transaction-level model
// kept in the bench.
// ---------------------------------------------------------------------------
module tb_axi4_lite_master_write_engine;

    localparam int AW      = 32;
    localparam int DW      = 32;
    localparam int SW      = DW / 8;
    localparam int CW      = 4;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic          aclk;
    logic          areset;
    logic          req_valid;
    logic          req_ready;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_data;
    logic [SW-1:0] req_strb;
    logic [2:0]    req_prot;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [1:0]    rsp_resp;
    logic [AW-1:0] awaddr;
    logic [2:0]    awprot;
    logic          awvalid;
    logic          awready;
    logic [DW-1:0] wdata;
    logic [SW-1:0] wstrb;
    logic          wvalid;
    logic          wready;
    logic [1:0]    bresp;
    logic          bvalid;
    logic          bready;
    logic [CW-1:0] wr_count;
    logic [CW-1:0] err_count;

    int checkCount = 0;
    int passCount  = 0;
    int modelWr    = 0;
    int modelErr   = 0;

    axi4_lite_master_write_engine #(
        .ADDRESS_WIDTH (AW),
        .DATA_WIDTH    (DW),
        .CNT_WIDTH     (CW)
    ) dut (
        .aclk      (aclk),
        .areset    (areset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .req_strb  (req_strb),
        .req_prot  (req_prot),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_resp  (rsp_resp),
        .awaddr    (awaddr),
        .awprot    (awprot),
        .awvalid   (awvalid),
        .awready   (awready),
        .wdata     (wdata),
        .wstrb     (wstrb),
        .wvalid    (wvalid),
        .wready    (wready),
        .bresp     (bresp),
        .bvalid    (bvalid),
        .bready    (bready),
        .wr_count  (wr_count),
        .err_count (err_count)
    );

    // Free-running 10 ns clock.
    initial begin
        aclk = 1'b0;
        forever #5 aclk = ~aclk;
    end

    // Guard against the run never reaching its summary.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Advance one clock and settle just past the edge.
    task automatic tick;
        @(posedge aclk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    endtask

    // Transaction-level bookkeeping: counts simply grow by one and clip.
    task automatic modelComplete(input logic [1:0] resp);
        modelWr = (modelWr + 1 > CNT_MAX) ? CNT_MAX : modelWr + 1;
        if (resp != 2'b00) begin
            modelErr = (modelErr + 1 > CNT_MAX) ? CNT_MAX : modelErr + 1;
        end
    endtask

    // One full write. The slave holds awready/wready low for awDelay/wDelay
    // cycles after acceptance, delays bvalid by bDelay cycles and the
    // requester withholds rsp_ready for rspDelay cycles.
    task automatic applyStimulus(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                                 input logic [SW-1:0] strb, input logic [2:0] prot,
                                 input logic [1:0] resp, input int awDelay,
                                 input int wDelay, input int bDelay, input int rspDelay);
        bit awDone;
        bit wDone;
        int cyc;
        req_addr  = addr;
        req_data  = data;
        req_strb  = strb;
        req_prot  = prot;
        req_valid = 1'b1;
        checkOutput("req_ready_idle", {63'd0, req_ready}, 64'd1);
        tick;
        req_valid = 1'b0;
        req_addr  = $urandom;
        req_data  = $urandom;
        req_strb  = SW'($urandom);
        req_prot  = 3'($urandom);
        checkOutput("req_ready_busy", {63'd0, req_ready}, 64'd0);
        awDone = 1'b0;
        wDone  = 1'b0;
        cyc    = 1;
        while (!(awDone && wDone)) begin
            awready = (cyc > awDelay);
            wready  = (cyc > wDelay);
            bvalid  = 1'b1;
            bresp   = 2'($urandom);
            checkOutput("awvalid", {63'd0, awvalid}, {63'd0, !awDone});
            checkOutput("wvalid", {63'd0, wvalid}, {63'd0, !wDone});
            checkOutput("bready_early", {63'd0, bready}, 64'd0);
            if (!awDone) begin
                checkOutput("awaddr", {32'd0, awaddr}, {32'd0, addr});
                checkOutput("awprot", {61'd0, awprot}, {61'd0, prot});
            end
            if (!wDone) begin
                checkOutput("wdata", {32'd0, wdata}, {32'd0, data});
                checkOutput("wstrb", {60'd0, wstrb}, {60'd0, strb});
            end
            awDone = awDone || awready;
            wDone  = wDone || wready;
            tick;
            awready = 1'b0;
            wready  = 1'b0;
            cyc++;
        end
        checkOutput("awvalid_after", {63'd0, awvalid}, 64'd0);
        checkOutput("wvalid_after", {63'd0, wvalid}, 64'd0);
        bvalid = 1'b0;
        for (int i = 0; i < bDelay; i++) begin
            checkOutput("bready_wait", {63'd0, bready}, 64'd1);
            tick;
        end
        bvalid = 1'b1;
        bresp  = resp;
        checkOutput("bready", {63'd0, bready}, 64'd1);
        checkOutput("rsp_valid_before_b", {63'd0, rsp_valid}, 64'd0);
        tick;
        bvalid = 1'b0;
        bresp  = 2'b00;
        modelComplete(resp);
        checkOutput("bready_after_b", {63'd0, bready}, 64'd0);
        for (int i = 0; i < rspDelay; i++) begin
            checkOutput("rsp_valid_hold", {63'd0, rsp_valid}, 64'd1);
            checkOutput("rsp_resp_hold", {62'd0, rsp_resp}, {62'd0, resp});
            checkOutput("req_ready_resp", {63'd0, req_ready}, 64'd0);
            tick;
        end
        rsp_ready = 1'b1;
        checkOutput("rsp_valid", {63'd0, rsp_valid}, 64'd1);
        checkOutput("rsp_resp", {62'd0, rsp_resp}, {62'd0, resp});
        checkOutput("req_ready_resp", {63'd0, req_ready}, 64'd0);
        checkOutput("wr_count", {60'd0, wr_count}, 64'(modelWr));
        checkOutput("err_count", {60'd0, err_count}, 64'(modelErr));
        tick;
        rsp_ready = 1'b0;
        checkOutput("rsp_valid_done", {63'd0, rsp_valid}, 64'd0);
        checkOutput("req_ready_done", {63'd0, req_ready}, 64'd1);
    endtask

    // Directed scenarios followed by a randomised run that also drives the
    // counters into saturation.
    initial begin
        areset    = 1'b1;
        req_valid = 1'b0;
        req_addr  = '0;
        req_data  = '0;
        req_strb  = '0;
        req_prot  = '0;
        rsp_ready = 1'b0;
        awready   = 1'b0;
        wready    = 1'b0;
        bresp     = 2'b00;
        bvalid    = 1'b0;
        repeat (3) tick;
        areset = 1'b0;

        $display("[TB] reset state");
        checkOutput("rst_req_ready", {63'd0, req_ready}, 64'd1);
        checkOutput("rst_awvalid", {63'd0, awvalid}, 64'd0);
        checkOutput("rst_wvalid", {63'd0, wvalid}, 64'd0);
        checkOutput("rst_bready", {63'd0, bready}, 64'd0);
        checkOutput("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        checkOutput("rst_awaddr", {32'd0, awaddr}, 64'd0);
        checkOutput("rst_wdata", {32'd0, wdata}, 64'd0);
        checkOutput("rst_wstrb", {60'd0, wstrb}, 64'd0);
        checkOutput("rst_rsp_resp", {62'd0, rsp_resp}, 64'd0);
        checkOutput("rst_wr_count", {60'd0, wr_count}, 64'd0);
        checkOutput("rst_err_count", {60'd0, err_count}, 64'd0);

        $display("[TB] single write, minimum latency");
        applyStimulus(32'h10, 32'hDEADBEEF, 4'hF, 3'b000, 2'b00, 0, 0, 0, 0);

        $display("[TB] skewed channels");
        applyStimulus($urandom, $urandom, 4'h3, 3'b010, 2'b00, 5, 0, 1, 0);
        applyStimulus($urandom, $urandom, 4'hC, 3'b101, 2'b00, 0, 4, 0, 0);

        $display("[TB] error responses");
        applyStimulus($urandom, $urandom, 4'hF, 3'b001, 2'b10, 1, 1, 2, 0);
        applyStimulus($urandom, $urandom, 4'h1, 3'b111, 2'b11, 0, 2, 0, 1);

        $display("[TB] response backpressure");
        applyStimulus($urandom, $urandom, 4'h5, 3'b000, 2'b01, 0, 0, 0, 10);

        $display("[TB] bvalid in IDLE");
        bvalid = 1'b1;
        bresp  = 2'b10;
        checkOutput("idle_bready", {63'd0, bready}, 64'd0);
        tick;
        bvalid = 1'b0;
        bresp  = 2'b00;
        checkOutput("idle_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        checkOutput("idle_req_ready", {63'd0, req_ready}, 64'd1);
        checkOutput("idle_wr_count", {60'd0, wr_count}, 64'(modelWr));
        checkOutput("idle_err_count", {60'd0, err_count}, 64'(modelErr));

        $display("[TB] reset mid-transaction");
        req_addr  = 32'hCAFE0000;
        req_data  = 32'h12345678;
        req_strb  = 4'hF;
        req_prot  = 3'b011;
        req_valid = 1'b1;
        tick;
        req_valid = 1'b0;
        checkOutput("midop_awvalid", {63'd0, awvalid}, 64'd1);
        areset = 1'b1;
        tick;
        areset   = 1'b0;
        modelWr  = 0;
        modelErr = 0;
        checkOutput("midop_awvalid_rst", {63'd0, awvalid}, 64'd0);
        checkOutput("midop_wvalid_rst", {63'd0, wvalid}, 64'd0);
        checkOutput("midop_bready_rst", {63'd0, bready}, 64'd0);
        checkOutput("midop_rsp_valid_rst", {63'd0, rsp_valid}, 64'd0);
        checkOutput("midop_req_ready_rst", {63'd0, req_ready}, 64'd1);
        checkOutput("midop_awaddr_rst", {32'd0, awaddr}, 64'd0);
        checkOutput("midop_wr_count_rst", {60'd0, wr_count}, 64'd0);
        checkOutput("midop_err_count_rst", {60'd0, err_count}, 64'd0);
        applyStimulus(32'h20, 32'hA5A5A5A5, 4'hF, 3'b000, 2'b00, 0, 0, 0, 0);

        $display("[TB] randomised writes into saturation");
        for (int n = 0; n < 17; n++) begin
            applyStimulus($urandom, $urandom, 4'($urandom), 3'($urandom),
                          2'($urandom), $urandom_range(0, 3), $urandom_range(0, 3),
                          $urandom_range(0, 2), $urandom_range(0, 2));
        end
        checkOutput("sat_wr_count", {60'd0, wr_count}, 64'(CNT_MAX));
        repeat (3) tick;
        checkOutput("sat_wr_count_hold", {60'd0, wr_count}, 64'(CNT_MAX));

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
